// File: rtl/sd_test_pkg.sv
// sd_test_pkg: constants and types shared by the SD-card probe.
package sd_test_pkg;

   // CMD0 (GO_IDLE_STATE) as sent on the wire: index, 32-bit argument, CRC7 plus stop bit.
   localparam logic [47:0] CMD0_FRAME  = 48'h40_0000_0000_95;
   localparam int          CMD0_BYTES  = 6;

   // R1 reply of a card that has entered the idle state.
   localparam logic [7:0]  R1_EXPECTED = 8'h01;

   typedef enum logic [2:0] {
      INIT,
      SEL,
      CMD,
      R1,
      END,
      DONE
   } state_e;

   // Byte idx of the CMD0 frame, first byte on the wire at idx 0.
   function automatic logic [7:0] cmd0Byte(input logic [2:0] idx);
      logic [47:0] frame;
      frame = CMD0_FRAME << (8 * idx);
      return frame[47:40];
   endfunction

endpackage

// File: rtl/sd_test_if.sv
// sd_test_if: SD socket wires (SPI mode) plus the two status flags for the test UI.
interface sd_test_if;

   logic spi_clk;
   logic spi_di;
   logic spi_do;
   logic spi_cs;
   logic test_in_progress;
   logic test_result;

   modport master (
      output spi_clk, spi_di, spi_cs, test_in_progress, test_result,
      input  spi_do
   );

   modport slave (
      input  spi_clk, spi_di, spi_cs, test_in_progress, test_result,
      output spi_do
   );

endinterface

// File: rtl/sd_spi_shift.sv
// sd_spi_shift: SPI mode-0 clock divider and 8-bit full-duplex shifter.
// A start may arrive in the same cycle as done, so consecutive bytes run back to back
// without stretching the spi_clk period.
module sd_spi_shift #(
   parameter int CLK_DIV = 32
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] tx_byte_i,
   input  logic       cs_hold_i,
   input  logic       spi_do_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rx_byte_o,
   output logic       spi_clk_o,
   output logic       spi_di_o,
   output logic       spi_cs_o
);

   localparam int              DIVW     = $clog2(CLK_DIV);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

   logic [DIVW-1:0] divCnt_q, divCnt_d;
   logic            sclk_q, sclk_d;
   logic [2:0]      bitCnt_q, bitCnt_d;
   logic            busy_q, busy_d;
   logic [7:0]      txSh_q, txSh_d;
   logic [7:0]      rxSh_q, rxSh_d;
   logic            cs_q, cs_d;
   logic            tick;

   assign tick   = busy_q && (divCnt_q == DIV_LAST);
   assign done_o = tick && sclk_q && (bitCnt_q == 3'd7);

   // Next state: load on start, otherwise toggle spi_clk every CLK_DIV cycles, sampling on rise and shifting on fall.
   always_comb begin
      divCnt_d = divCnt_q;
      sclk_d   = sclk_q;
      bitCnt_d = bitCnt_q;
      busy_d   = busy_q;
      txSh_d   = txSh_q;
      rxSh_d   = rxSh_q;
      cs_d     = cs_q;
      if (start_i) begin
         busy_d   = 1'b1;
         divCnt_d = '0;
         sclk_d   = 1'b0;
         bitCnt_d = 3'd0;
         txSh_d   = tx_byte_i;
         cs_d     = cs_hold_i;
      end else if (busy_q) begin
         if (tick) begin
            divCnt_d = '0;
            sclk_d   = ~sclk_q;
            if (!sclk_q) begin
               rxSh_d = {rxSh_q[6:0], spi_do_i};
            end else begin
               txSh_d   = {txSh_q[6:0], 1'b1};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  busy_d = 1'b0;
               end
            end
         end else begin
            divCnt_d = divCnt_q + 1'b1;
         end
      end
   end

   // State registers; reset parks the bus idle with the card deselected.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         divCnt_q <= '0;
         sclk_q   <= 1'b0;
         bitCnt_q <= 3'd0;
         busy_q   <= 1'b0;
         txSh_q   <= 8'hFF;
         rxSh_q   <= 8'hFF;
         cs_q     <= 1'b1;
      end else begin
         divCnt_q <= divCnt_d;
         sclk_q   <= sclk_d;
         bitCnt_q <= bitCnt_d;
         busy_q   <= busy_d;
         txSh_q   <= txSh_d;
         rxSh_q   <= rxSh_d;
         cs_q     <= cs_d;
      end
   end

   assign busy_o    = busy_q;
   assign rx_byte_o = rxSh_q;
   assign spi_clk_o = sclk_q;
   assign spi_di_o  = busy_q ? txSh_q[7] : 1'b1;
   assign spi_cs_o  = cs_q;

endmodule

// File: rtl/sd_test.sv
// sd_test: one-shot SD-card probe; sends idle clocks and CMD0, then grades the R1 reply.
module sd_test
   import sd_test_pkg::*;
#(
   parameter int CLK_DIV   = 32,
   parameter int INIT_CLKS = 80,
   parameter int NCR_MAX   = 16
) (
   input  logic      clk,
   input  logic      rst,
   sd_test_if.master bus
);

   localparam logic [7:0] INIT_LAST = 8'((INIT_CLKS + 7) / 8 - 1);
   localparam logic [7:0] CMD_LAST  = 8'(CMD0_BYTES - 1);
   localparam logic [7:0] NCR_LAST  = 8'(NCR_MAX - 1);

   state_e     state_q, state_d;
   logic [7:0] byteCnt_q, byteCnt_d;
   logic [7:0] r1_q, r1_d;
   logic       timeout_q, timeout_d;
   logic       result_q, result_d;
   logic       inProg_q, inProg_d;

   logic       shStart;
   logic       shBusy;
   logic       shDone;
   logic       shCsHold;
   logic [7:0] shTx;
   logic [7:0] shRx;

   sd_spi_shift #(
      .CLK_DIV(CLK_DIV)
   ) u_shift (
      .clk_i    (clk),
      .rst_ni   (rst),
      .start_i  (shStart),
      .tx_byte_i(shTx),
      .cs_hold_i(shCsHold),
      .spi_do_i (bus.spi_do),
      .busy_o   (shBusy),
      .done_o   (shDone),
      .rx_byte_o(shRx),
      .spi_clk_o(bus.spi_clk),
      .spi_di_o (bus.spi_di),
      .spi_cs_o (bus.spi_cs)
   );

   // Sequencer: advance one byte per shifter done and pick the byte/chip-select for the next one.
   always_comb begin
      state_d   = state_q;
      byteCnt_d = byteCnt_q;
      r1_d      = r1_q;
      timeout_d = timeout_q;
      result_d  = result_q;
      inProg_d  = inProg_q;
      if (shDone) begin
         case (state_q)
            INIT: begin
               if (byteCnt_q == INIT_LAST) begin
                  state_d   = SEL;
                  byteCnt_d = 8'd0;
               end else begin
                  byteCnt_d = byteCnt_q + 8'd1;
               end
            end
            SEL: begin
               state_d   = CMD;
               byteCnt_d = 8'd0;
            end
            CMD: begin
               if (byteCnt_q == CMD_LAST) begin
                  state_d   = R1;
                  byteCnt_d = 8'd0;
               end else begin
                  byteCnt_d = byteCnt_q + 8'd1;
               end
            end
            R1: begin
               if (!shRx[7]) begin
                  r1_d    = shRx;
                  state_d = END;
               end else if (byteCnt_q == NCR_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = END;
               end else begin
                  byteCnt_d = byteCnt_q + 8'd1;
               end
            end
            END: begin
               state_d  = DONE;
               result_d = (r1_q == R1_EXPECTED) && !timeout_q;
               inProg_d = 1'b0;
            end
            default: ;
         endcase
      end
      shStart  = (state_d != DONE) && (!shBusy || shDone);
      shCsHold = !(state_d inside {SEL, CMD, R1});
      shTx     = (state_d == CMD) ? cmd0Byte(byteCnt_d[2:0]) : 8'hFF;
   end

   // Sequencer and result registers; a reset at any time restarts the probe from INIT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= INIT;
         byteCnt_q <= 8'd0;
         r1_q      <= 8'hFF;
         timeout_q <= 1'b0;
         result_q  <= 1'b0;
         inProg_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         byteCnt_q <= byteCnt_d;
         r1_q      <= r1_d;
         timeout_q <= timeout_d;
         result_q  <= result_d;
         inProg_q  <= inProg_d;
      end
   end

   assign bus.test_in_progress = inProg_q;
   assign bus.test_result      = result_q;

endmodule

// File: tb/tb_sd_test.sv
// tb_sd_test: drives sd_test against a byte-level SD card model and grades each probe run.
`timescale 1ns/1ps
module tb_sd_test;

   localparam int          CLK_DIV    = 4;
   localparam int          INIT_CLKS  = 80;
   localparam int          NCR_MAX    = 16;
   localparam int          MAX_CYCLES = (INIT_CLKS + 8 + 48 + 8 * NCR_MAX + 8) * 2 * CLK_DIV + 16;
   localparam logic [47:0] CMD0       = 48'h40_0000_0000_95;

   logic clk = 1'b0;
   logic rst = 1'b0;

   sd_test_if bus();

   sd_test #(
      .CLK_DIV  (CLK_DIV),
      .INIT_CLKS(INIT_CLKS),
      .NCR_MAX  (NCR_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] modelResp[$];
   logic [7:0] respQ[$];
   logic [7:0] mosiQ[$];
   bit         monActive = 1'b0;
   int         riseCount, initRises, periodBad, diBad, sinceDi, sinceRise, mosiBits;
   bit         csFallSeen;
   logic [7:0] mosiByte, misoSh;
   logic       prevSclk = 1'b0, prevDi = 1'b1, prevCs = 1'b1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Card model and bus monitor, sampled on the falling clk edge away from DUT updates.
   initial begin
      bus.spi_do = 1'b1;
      forever begin
         @(negedge clk);
         if (!monActive) begin
            bus.spi_do = 1'b1;
            mosiQ.delete();
            mosiBits   = 0;
            mosiByte   = 8'h00;
            misoSh     = 8'hFF;
            riseCount  = 0;
            initRises  = 0;
            csFallSeen = 1'b0;
            periodBad  = 0;
            diBad      = 0;
            sinceDi    = 0;
            sinceRise  = 0;
         end else begin
            sinceDi++;
            sinceRise++;
            if (bus.spi_di !== prevDi) begin
               if (prevSclk && bus.spi_clk) diBad++;
               sinceDi = 0;
            end
            if (!prevSclk && bus.spi_clk) begin
               if (sinceDi < CLK_DIV) diBad++;
               if (riseCount > 0 && sinceRise != 2 * CLK_DIV) periodBad++;
               sinceRise = 0;
               riseCount++;
               if (!csFallSeen) initRises++;
               if (!bus.spi_cs) begin
                  mosiByte = {mosiByte[6:0], bus.spi_di};
                  mosiBits++;
                  if (mosiBits == 8) begin
                     mosiQ.push_back(mosiByte);
                     mosiBits = 0;
                  end
               end
            end
            if (prevCs && !bus.spi_cs) csFallSeen = 1'b1;
            if (prevSclk && !bus.spi_clk) begin
               if (bus.spi_cs) begin
                  bus.spi_do = 1'b1;
               end else begin
                  if (mosiBits == 0) begin
                     if (mosiQ.size() >= 7 && respQ.size() > 0) misoSh = respQ.pop_front();
                     else misoSh = 8'hFF;
                  end
                  bus.spi_do = misoSh[7];
                  misoSh     = {misoSh[6:0], 1'b1};
               end
            end
         end
         prevSclk = bus.spi_clk;
         prevDi   = bus.spi_di;
         prevCs   = bus.spi_cs;
      end
   end

   // Reference: scan the card's reply stream the way an SD host reads R1.
   function automatic void refModel(output int polled, output bit pass);
      logic [7:0] b;
      bit         found;
      polled = NCR_MAX;
      pass   = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < NCR_MAX; i++) begin
         b = (i < modelResp.size()) ? modelResp[i] : 8'hFF;
         if (!found && b < 8'h80) begin
            found  = 1'b1;
            polled = i + 1;
            pass   = (b == 8'h01);
         end
      end
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".cs"},     bus.spi_cs, 1);
      checkOutput({tag, ".sclk"},   bus.spi_clk, 0);
      checkOutput({tag, ".di"},     bus.spi_di, 1);
      checkOutput({tag, ".inprog"}, bus.test_in_progress, 1);
      checkOutput({tag, ".result"}, bus.test_result, 0);
   endtask

   task automatic releaseReset();
      respQ.delete();
      foreach (modelResp[i]) respQ.push_back(modelResp[i]);
      monActive = 1'b1;
      rst       = 1'b1;
   endtask

   task automatic applyStimulus(input string tag);
      @(negedge clk);
      rst       = 1'b0;
      monActive = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs({tag, ".rst"});
      releaseReset();
   endtask

   task automatic runToEnd(input string tag);
      int         cycles, polled, badPoll, rises;
      bit         pass;
      logic [7:0] b;
      refModel(polled, pass);
      cycles = 0;
      while (bus.test_in_progress === 1'b1 && cycles <= MAX_CYCLES) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, ".bound"},  (cycles <= MAX_CYCLES), 1);
      checkOutput({tag, ".result"}, bus.test_result, pass);
      checkOutput({tag, ".cs"},     bus.spi_cs, 1);
      checkOutput({tag, ".sclk"},   bus.spi_clk, 0);
      checkOutput({tag, ".di"},     bus.spi_di, 1);
      checkOutput({tag, ".initclk"}, initRises, INIT_CLKS);
      checkOutput({tag, ".rises"},  riseCount, INIT_CLKS + 8 * (8 + polled));
      checkOutput({tag, ".nbytes"}, mosiQ.size(), 7 + polled);
      b = (mosiQ.size() > 0) ? mosiQ[0] : 8'h00;
      checkOutput({tag, ".sel"}, b, 8'hFF);
      for (int i = 0; i < 6; i++) begin
         b = (i + 1 < mosiQ.size()) ? mosiQ[i + 1] : 8'h00;
         checkOutput($sformatf("%s.cmd%0d", tag, i), b, CMD0[47 - 8 * i -: 8]);
      end
      badPoll = 0;
      for (int i = 7; i < mosiQ.size(); i++) if (mosiQ[i] != 8'hFF) badPoll++;
      checkOutput({tag, ".polldi"}, badPoll, 0);
      checkOutput({tag, ".period"}, periodBad, 0);
      checkOutput({tag, ".mode0"},  diBad, 0);
      rises = riseCount;
      repeat (40) @(negedge clk);
      checkOutput({tag, ".hold.inprog"}, bus.test_in_progress, 0);
      checkOutput({tag, ".hold.result"}, bus.test_result, pass);
      checkOutput({tag, ".hold.idle"},   riseCount, rises);
   endtask

   // Main sequence: directed cases, a mid-command reset, then randomized card replies.
   initial begin
      int         n, cycles;
      logic [7:0] last;

      modelResp.delete();
      applyStimulus("nocard");
      runToEnd("nocard");

      modelResp = '{8'hFF, 8'hFF, 8'h01};
      applyStimulus("pass");
      runToEnd("pass");

      modelResp = '{8'hFF, 8'h05};
      applyStimulus("r1x05");
      runToEnd("r1x05");

      modelResp.delete();
      for (int i = 0; i < NCR_MAX - 1; i++) modelResp.push_back(8'hFF);
      modelResp.push_back(8'h01);
      applyStimulus("lastpoll");
      runToEnd("lastpoll");

      modelResp.delete();
      for (int i = 0; i < NCR_MAX; i++) modelResp.push_back(8'hFF);
      modelResp.push_back(8'h01);
      applyStimulus("latereply");
      runToEnd("latereply");

      modelResp = '{8'hFF, 8'hFF, 8'h01};
      applyStimulus("rstcmd");
      cycles = 0;
      while (mosiQ.size() < 3 && cycles < MAX_CYCLES) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("rstcmd.reach", (mosiQ.size() >= 3), 1);
      checkOutput("rstcmd.sel",   bus.spi_cs, 0);
      rst       = 1'b0;
      monActive = 1'b0;
      @(negedge clk);
      checkResetOutputs("rstcmd.abort");
      repeat (2) @(negedge clk);
      releaseReset();
      runToEnd("rstcmd");

      for (int r = 0; r < 8; r++) begin
         modelResp.delete();
         n = $urandom_range(0, NCR_MAX + 1);
         for (int i = 0; i < n; i++) modelResp.push_back(8'h80 | 8'($urandom_range(0, 127)));
         case ($urandom_range(0, 3))
            0:       last = 8'h01;
            1:       last = 8'h00;
            2:       last = 8'($urandom_range(0, 127));
            default: last = 8'h7F;
         endcase
         modelResp.push_back(last);
         applyStimulus($sformatf("rand%0d", r));
         runToEnd($sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
